// File: rtl/tm1638_display_scheduler_if.sv
// Bus between the four display sources / TM1638 driver and the display scheduler.
// The scheduler takes the slave modport; the source/driver side takes master.
interface tm1638_display_scheduler_if;
   logic          tick;
   logic [3:0]    req;
   logic [127:0]  src_data;
   logic [31:0]   src_leds;
   logic [31:0]   src_dots;
   logic [7:0]    keys;
   logic [31:0]   disp_data;
   logic [7:0]    disp_leds;
   logic [7:0]    disp_dots;
   logic          disp_bcd;
   logic [1:0]    active_src;
   logic          active_valid;
   logic          pinned;

   modport master (
      output tick, req, src_data, src_leds, src_dots, keys,
      input  disp_data, disp_leds, disp_dots, disp_bcd, active_src, active_valid, pinned
   );

   modport slave (
      input  tick, req, src_data, src_leds, src_dots, keys,
      output disp_data, disp_leds, disp_dots, disp_bcd, active_src, active_valid, pinned
   );
endinterface

// File: rtl/tm1638_display_scheduler.sv
// Time-shares one TM1638 board between four sources: round-robin dwell in auto mode,
// key-pinned source in manual mode. Optional macro SRC_INDICATOR_EN puts a one-hot
// source indicator on disp_leds[7:4].
//
// state  | meaning
// S_IDLE | no source shown, display blank
// S_SHOW | auto mode, active source holds display for DWELL_TICKS ticks
// S_PIN  | manual mode, source pinned by key 0..3, key 7 releases
module tm1638_display_scheduler #(
   parameter int unsigned DWELL_TICKS = 4,
   parameter logic [3:0]  BCD_MASK    = 4'b0001
) (
   input  logic                         i_clk,
   input  logic                         i_n_rst,
   tm1638_display_scheduler_if.slave    bus
);

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_PIN} state_t;

   localparam logic [15:0] DWELL_LAST = 16'(DWELL_TICKS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_ptr;
   logic [1:0]  w_ptr_nxt;
   logic [1:0]  w_src_nxt;
   logic [15:0] r_dwell;
   logic [15:0] w_dwell_nxt;
   logic [7:0]  r_key_q;
   logic [7:0]  w_key_rise;
   logic        w_pin_req;
   logic        w_unpin_req;
   logic [1:0]  w_pin_idx;
   logic [1:0]  w_arb_from;
   logic        w_arb_found;
   logic [1:0]  w_arb_idx;
   logic        w_valid_nxt;
   logic [7:0]  w_leds_sel;
   logic [7:0]  w_leds_nxt;

   assign w_key_rise  = bus.keys & ~r_key_q;
   assign w_unpin_req = w_key_rise[7];
   // key 7 outranks any simultaneous pin key
   assign w_pin_req   = (|w_key_rise[3:0]) & ~w_key_rise[7];

   always_comb begin
      w_pin_idx = 2'd0;
      if (w_key_rise[0])      w_pin_idx = 2'd0;
      else if (w_key_rise[1]) w_pin_idx = 2'd1;
      else if (w_key_rise[2]) w_pin_idx = 2'd2;
      else if (w_key_rise[3]) w_pin_idx = 2'd3;
   end

   // On unpin the search starts just before the pinned source so it is preferred.
   assign w_arb_from = (r_state == S_PIN) ? (bus.active_src - 2'd1) : r_ptr;

   // Scan far-to-near so the nearest requester after w_arb_from is the last write.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = w_arb_from;
      for (int k = 4; k >= 1; k--) begin
         if (bus.req[w_arb_from + 2'(k)]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_arb_from + 2'(k);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = bus.active_src;
      w_ptr_nxt   = r_ptr;
      w_dwell_nxt = r_dwell;
      case (r_state)
         S_IDLE: begin
            if (w_pin_req) begin
               w_state_nxt = S_PIN;
               w_src_nxt   = w_pin_idx;
            end else if (w_arb_found) begin
               w_state_nxt = S_SHOW;
               w_src_nxt   = w_arb_idx;
               w_ptr_nxt   = w_arb_idx;
               w_dwell_nxt = 16'd0;
            end
         end
         S_SHOW: begin
            if (w_pin_req) begin
               w_state_nxt = S_PIN;
               w_src_nxt   = w_pin_idx;
            end else if (!bus.req[bus.active_src] || (bus.tick && (r_dwell == DWELL_LAST))) begin
               w_dwell_nxt = 16'd0;
               if (w_arb_found) begin
                  w_src_nxt = w_arb_idx;
                  w_ptr_nxt = w_arb_idx;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_src_nxt   = 2'd0;
               end
            end else if (bus.tick) begin
               w_dwell_nxt = r_dwell + 16'd1;
            end
         end
         S_PIN: begin
            if (w_unpin_req) begin
               w_dwell_nxt = 16'd0;
               if (w_arb_found) begin
                  w_state_nxt = S_SHOW;
                  w_src_nxt   = w_arb_idx;
                  w_ptr_nxt   = w_arb_idx;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_src_nxt   = 2'd0;
               end
            end else if (w_pin_req) begin
               w_src_nxt = w_pin_idx;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_src_nxt   = 2'd0;
         end
      endcase
   end

   assign w_valid_nxt = (w_state_nxt != S_IDLE);
   assign w_leds_sel  = bus.src_leds[{w_src_nxt, 3'd0} +: 8];

`ifdef SRC_INDICATOR_EN
   assign w_leds_nxt = {4'b0001 << w_src_nxt, w_leds_sel[3:0]};
`else
   assign w_leds_nxt = w_leds_sel;
`endif

   always_ff @(posedge i_clk or posedge i_n_rst) begin
      if (i_n_rst) begin
         r_state          <= S_IDLE;
         r_ptr            <= 2'd3;
         r_dwell          <= 16'd0;
         r_key_q          <= 8'd0;
         bus.active_src   <= 2'd0;
         bus.active_valid <= 1'b0;
         bus.pinned       <= 1'b0;
         bus.disp_data    <= 32'd0;
         bus.disp_leds    <= 8'd0;
         bus.disp_dots    <= 8'd0;
         bus.disp_bcd     <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_ptr            <= w_ptr_nxt;
         r_dwell          <= w_dwell_nxt;
         r_key_q          <= bus.keys;
         bus.active_src   <= w_src_nxt;
         bus.active_valid <= w_valid_nxt;
         bus.pinned       <= (w_state_nxt == S_PIN);
         bus.disp_data    <= w_valid_nxt ? bus.src_data[{w_src_nxt, 5'd0} +: 32] : 32'd0;
         bus.disp_leds    <= w_valid_nxt ? w_leds_nxt : 8'd0;
         bus.disp_dots    <= w_valid_nxt ? bus.src_dots[{w_src_nxt, 3'd0} +: 8] : 8'd0;
         bus.disp_bcd     <= w_valid_nxt & BCD_MASK[w_src_nxt];
      end
   end

endmodule

// File: tb/tb_tm1638_display_scheduler.sv
// Directed bench for tm1638_display_scheduler (DWELL_TICKS = 3, BCD on source 0 only).
module tb_tm1638_display_scheduler;

   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   always #5 clk = ~clk;

   tm1638_display_scheduler_if bus();

   tm1638_display_scheduler #(.DWELL_TICKS(3), .BCD_MASK(4'b0001)) dut (
      .i_clk   (clk),
      .i_n_rst (n_rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] sd [4];
   logic [7:0]  sl [4];
   logic [7:0]  so [4];

   function automatic logic [7:0] exp_leds(input logic [1:0] s, input logic [7:0] l);
`ifdef SRC_INDICATOR_EN
      return {4'b0001 << s, l[3:0]};
`else
      return l;
`endif
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_src();
      bus.src_data = {sd[3], sd[2], sd[1], sd[0]};
      bus.src_leds = {sl[3], sl[2], sl[1], sl[0]};
      bus.src_dots = {so[3], so[2], so[1], so[0]};
   endtask

   // n ticks, each followed by 9 idle clocks
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         repeat (9) step();
      end
   endtask

   task automatic chk_show(input string tag, input logic [1:0] s, input logic pin);
      chk({tag, ".valid"}, 128'(bus.active_valid), 128'(1'b1));
      chk({tag, ".src"},   128'(bus.active_src),   128'(s));
      chk({tag, ".pin"},   128'(bus.pinned),       128'(pin));
      chk({tag, ".data"},  128'(bus.disp_data),    128'(sd[s]));
      chk({tag, ".leds"},  128'(bus.disp_leds),    128'(exp_leds(s, sl[s])));
      chk({tag, ".dots"},  128'(bus.disp_dots),    128'(so[s]));
      chk({tag, ".bcd"},   128'(bus.disp_bcd),     128'(s == 2'd0));
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, ".valid"}, 128'(bus.active_valid), 128'(1'b0));
      chk({tag, ".src"},   128'(bus.active_src),   128'(2'd0));
      chk({tag, ".pin"},   128'(bus.pinned),       128'(1'b0));
      chk({tag, ".data"},  128'(bus.disp_data),    128'(32'd0));
      chk({tag, ".leds"},  128'(bus.disp_leds),    128'(8'd0));
      chk({tag, ".dots"},  128'(bus.disp_dots),    128'(8'd0));
      chk({tag, ".bcd"},   128'(bus.disp_bcd),     128'(1'b0));
   endtask

   initial begin
      sd[0] = 32'hAAAA_0000; sd[1] = 32'h1234_5678; sd[2] = 32'hCCCC_0002; sd[3] = 32'hDDDD_0003;
      sl[0] = 8'h11;         sl[1] = 8'h22;         sl[2] = 8'h33;         sl[3] = 8'hFF;
      so[0] = 8'h0A;         so[1] = 8'h0B;         so[2] = 8'h0C;         so[3] = 8'h0D;
      apply_src();
      bus.tick = 1'b0;
      bus.req  = 4'b0000;
      bus.keys = 8'h00;

      // reset, then blank with no requests
      repeat (3) step();
      n_rst = 1'b0;
      step();
      chk_blank("reset");
      repeat (2) step();
      chk_blank("idle_noreq");

      // rotation 0 -> 2 -> 0 with three ticks each
      bus.req = 4'b0101;
      step();
      chk_show("rot_first", 2'd0, 1'b0);
      ticks(2);
      chk_show("rot_hold0", 2'd0, 1'b0);
      ticks(1);
      chk_show("rot_to2", 2'd2, 1'b0);
      ticks(2);
      chk_show("rot_hold2", 2'd2, 1'b0);
      ticks(1);
      chk_show("rot_back0", 2'd0, 1'b0);
      sd[0] = 32'h0BAD_F00D;
      apply_src();
      step();
      chk("data_follow", 128'(bus.disp_data), 128'(32'h0BAD_F00D));

      // sole requester: drop of req[0] moves to 1 on the next edge, then stays
      bus.req = 4'b0010;
      step();
      chk_show("sole_sel", 2'd1, 1'b0);
      ticks(9);
      chk_show("sole_hold", 2'd1, 1'b0);

      // drop mid-dwell
      bus.req = 4'b0011;
      ticks(3);
      chk_show("drop_at0", 2'd0, 1'b0);
      ticks(1);
      bus.req = 4'b0010;
      step();
      chk_show("drop_to1", 2'd1, 1'b0);
      bus.req = 4'b0011;
      ticks(2);
      chk_show("drop_dwell_clr", 2'd1, 1'b0);
      ticks(1);
      chk_show("drop_expire", 2'd0, 1'b0);
      bus.req = 4'b0000;
      step();
      chk_blank("drop_all");

      // pin / unpin
      bus.req = 4'b0001;
      step();
      chk_show("pre_pin", 2'd0, 1'b0);
      bus.keys = 8'h04;
      step();
      chk_show("pin2", 2'd2, 1'b1);
      repeat (19) step();
      ticks(10);
      chk_show("pin2_hold", 2'd2, 1'b1);
      bus.keys = 8'h00;
      step();
      bus.keys = 8'h82;
      step();
      chk_show("unpin_k7_wins", 2'd0, 1'b0);
      bus.keys = 8'h00;
      step();
      bus.keys = 8'h80;
      step();
      chk_show("k7_noop", 2'd0, 1'b0);
      bus.keys = 8'h70;
      step();
      chk_show("k456_ignored", 2'd0, 1'b0);
      bus.keys = 8'h00;
      bus.req  = 4'b0101;
      step();
      bus.keys = 8'h03;
      step();
      chk_show("pin_lowest", 2'd0, 1'b1);
      bus.keys = 8'h00;
      step();
      bus.keys = 8'h80;
      step();
      chk_show("unpin_prefers", 2'd0, 1'b0);
      bus.keys = 8'h00;

      // source 3 LEDs with indicator
      bus.req = 4'b1000;
      step();
      chk_show("src3", 2'd3, 1'b0);
`ifdef SRC_INDICATOR_EN
      chk("leds_ind", 128'(bus.disp_leds), 128'(8'h8F));
`else
      chk("leds_ind", 128'(bus.disp_leds), 128'(8'hFF));
`endif

      // asynchronous reset mid-show
      bus.req = 4'b0100;
      step();
      chk_show("pre_rst", 2'd2, 1'b0);
      #2 n_rst = 1'b1;
      #1 chk_blank("async_rst");
      #1 n_rst = 1'b0;
      bus.req = 4'b0000;
      step();
      step();
      chk_blank("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
